// File: rtl/vs_persp_divide.sv
// vs_persp_divide: renormalizes clip-space X/Y/Z/W products to Q.FRAC_BITS and
// divides X, Y, Z by W through one shared bit-serial restoring divider.
module vs_persp_divide #(
  parameter int FIXED_WIDTH = 16,
  parameter int FRAC_BITS   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [2*FIXED_WIDTH-1:0] Y0,
  input  logic signed [2*FIXED_WIDTH-1:0] Y1,
  input  logic signed [2*FIXED_WIDTH-1:0] Y2,
  input  logic signed [2*FIXED_WIDTH-1:0] Y3,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [FIXED_WIDTH-1:0]   out_x,
  output logic signed [FIXED_WIDTH-1:0]   out_y,
  output logic signed [FIXED_WIDTH-1:0]   out_z,
  output logic signed [FIXED_WIDTH-1:0]   out_w,
  output logic                            out_clip
);

  localparam int DIV_CYCLES = FIXED_WIDTH + FRAC_BITS;
  localparam int YW         = 2 * FIXED_WIDTH;
  localparam int CW         = $clog2(DIV_CYCLES);

  localparam logic [CW-1:0]                L_LAST    = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0]                L_CNT_ONE = CW'(1);
  localparam logic [CW-1:0]                L_CNT_ZERO = CW'(0);
  localparam logic signed [YW-1:0]         L_NMAX = {{(FIXED_WIDTH+1){1'b0}}, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic signed [YW-1:0]         L_NMIN = {{(FIXED_WIDTH+1){1'b1}}, {(FIXED_WIDTH-1){1'b0}}};
  localparam logic [DIV_CYCLES-1:0]        L_QMAX = {{(FRAC_BITS+1){1'b0}}, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [FIXED_WIDTH-1:0]       L_ONE  = {{(FIXED_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [FIXED_WIDTH-1:0] L_ZERO = {FIXED_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Arithmetic shift down to Q.FRAC_BITS, clamped to the signed FIXED_WIDTH range.
  function automatic logic signed [FIXED_WIDTH-1:0] f_norm(input logic signed [YW-1:0] y);
    logic signed [YW-1:0] s;
    s = y >>> FRAC_BITS;
    if (s > L_NMAX)      f_norm = L_NMAX[FIXED_WIDTH-1:0];
    else if (s < L_NMIN) f_norm = L_NMIN[FIXED_WIDTH-1:0];
    else                 f_norm = s[FIXED_WIDTH-1:0];
  endfunction

  function automatic logic [DIV_CYCLES-1:0] f_dividend(input logic signed [FIXED_WIDTH-1:0] n);
    logic [FIXED_WIDTH-1:0] mag;
    if (n[FIXED_WIDTH-1]) mag = ~n + L_ONE;
    else                  mag = n;
    f_dividend = {mag, {FRAC_BITS{1'b0}}};
  endfunction

  function automatic logic signed [FIXED_WIDTH-1:0] f_result(input logic [DIV_CYCLES-1:0] q,
                                                             input logic neg);
    logic [FIXED_WIDTH-1:0] mag;
    if (q > L_QMAX) mag = L_QMAX[FIXED_WIDTH-1:0];
    else            mag = q[FIXED_WIDTH-1:0];
    if (neg) f_result = ~mag + L_ONE;
    else     f_result = mag;
  endfunction

  state_t                        r_state;
  state_t                        w_next;
  logic signed [YW-1:0]          r_y0, r_y1, r_y2, r_y3;
  logic signed [FIXED_WIDTH-1:0] r_ny, r_nz, r_wn;
  logic [1:0]                    r_comp;
  logic [CW-1:0]                 r_cnt;
  logic [DIV_CYCLES-1:0]         r_dvd;
  logic [FIXED_WIDTH-1:0]        r_rem;
  logic                          r_neg;
  logic                          r_out_valid;

  logic signed [FIXED_WIDTH-1:0] w_nx, w_ny, w_nz, w_wn, w_next_n, w_res;
  logic                          w_clip, w_ge, w_last;
  logic [FIXED_WIDTH:0]          w_trial;
  logic [FIXED_WIDTH-1:0]        w_rem_next;
  logic [DIV_CYCLES-1:0]         w_quo_next;

  assign w_nx     = f_norm(r_y0);
  assign w_ny     = f_norm(r_y1);
  assign w_nz     = f_norm(r_y2);
  assign w_wn     = f_norm(r_y3);
  assign w_clip   = (w_wn <= L_ZERO);

  // Dividend bits leave r_dvd at the top while quotient bits enter at the bottom.
  assign w_trial    = {r_rem, r_dvd[DIV_CYCLES-1]};
  assign w_ge       = (w_trial >= {1'b0, r_wn});
  assign w_rem_next = w_ge ? FIXED_WIDTH'(w_trial - {1'b0, r_wn}) : w_trial[FIXED_WIDTH-1:0];
  assign w_quo_next = {r_dvd[DIV_CYCLES-2:0], w_ge};
  assign w_last     = (r_cnt == L_LAST);
  assign w_res      = f_result(w_quo_next, r_neg);
  assign w_next_n   = (r_comp == 2'd0) ? r_ny : r_nz;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next = S_NORM;
        else          w_next = S_IDLE;
      end
      S_NORM: begin
        if (w_clip) w_next = S_DONE;
        else        w_next = S_DIV;
      end
      S_DIV: begin
        if (w_last && (r_comp == 2'd2)) w_next = S_DONE;
        else                            w_next = S_DIV;
      end
      S_DONE: begin
        if (r_out_valid && out_ready) w_next = S_IDLE;
        else                          w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture, normalize, serial divide, and the output handshake register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y0        <= {YW{1'b0}};
      r_y1        <= {YW{1'b0}};
      r_y2        <= {YW{1'b0}};
      r_y3        <= {YW{1'b0}};
      r_ny        <= L_ZERO;
      r_nz        <= L_ZERO;
      r_wn        <= L_ZERO;
      r_comp      <= 2'd0;
      r_cnt       <= L_CNT_ZERO;
      r_dvd       <= {DIV_CYCLES{1'b0}};
      r_rem       <= {FIXED_WIDTH{1'b0}};
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
      out_x       <= L_ZERO;
      out_y       <= L_ZERO;
      out_z       <= L_ZERO;
      out_w       <= L_ZERO;
      out_clip    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_y0 <= Y0;
            r_y1 <= Y1;
            r_y2 <= Y2;
            r_y3 <= Y3;
          end
        end
        S_NORM: begin
          r_ny   <= w_ny;
          r_nz   <= w_nz;
          r_wn   <= w_wn;
          out_w  <= w_wn;
          r_comp <= 2'd0;
          r_cnt  <= L_CNT_ZERO;
          r_rem  <= {FIXED_WIDTH{1'b0}};
          r_dvd  <= f_dividend(w_nx);
          r_neg  <= w_nx[FIXED_WIDTH-1];
          if (w_clip) begin
            out_x    <= L_ZERO;
            out_y    <= L_ZERO;
            out_z    <= L_ZERO;
            out_clip <= 1'b1;
          end else begin
            out_clip <= 1'b0;
          end
        end
        S_DIV: begin
          if (w_last) begin
            case (r_comp)
              2'd0:    out_x <= w_res;
              2'd1:    out_y <= w_res;
              default: out_z <= w_res;
            endcase
            r_comp <= r_comp + 2'd1;
            r_cnt  <= L_CNT_ZERO;
            r_rem  <= {FIXED_WIDTH{1'b0}};
            r_dvd  <= f_dividend(w_next_n);
            r_neg  <= w_next_n[FIXED_WIDTH-1];
          end else begin
            r_cnt <= r_cnt + L_CNT_ONE;
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
          end
        end
        S_DONE: begin
          if (!r_out_valid)   r_out_valid <= 1'b1;
          else if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_vs_persp_divide.sv
// Self-checking bench for vs_persp_divide: directed cases, backpressure, abort
// by reset, and randomized vectors against an arithmetic reference model.
module tb_vs_persp_divide;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y0, y1, y2, y3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ox, oy, oz, ow;
  logic        oclip;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vs_persp_divide dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y0        (y0),
    .Y1        (y1),
    .Y2        (y2),
    .Y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (ox),
    .out_y     (oy),
    .out_z     (oz),
    .out_w     (ow),
    .out_clip  (oclip)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Floor division by 256, then clamp to int16.
  function automatic longint m_norm(input logic [31:0] y);
    longint v;
    v = longint'($signed(y));
    if (v >= 0) v = v / 256;
    else        v = -((-v + 255) / 256);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic longint m_div(input longint n, input longint w);
    longint q;
    q = (((n < 0) ? -n : n) * 256) / w;
    if (q > 32767) q = 32767;
    return (n < 0) ? -q : q;
  endfunction

  task automatic model(input logic [31:0] a, b, c, d,
                       output logic [15:0] ex, ey, ez, ew, output logic ec);
    longint nx, ny, nz, nw, rx, ry, rz;
    nx = m_norm(a); ny = m_norm(b); nz = m_norm(c); nw = m_norm(d);
    ew = nw[15:0];
    if (nw <= 0) begin
      ec = 1'b1; ex = 16'h0; ey = 16'h0; ez = 16'h0;
    end else begin
      ec = 1'b0;
      rx = m_div(nx, nw); ry = m_div(ny, nw); rz = m_div(nz, nw);
      ex = rx[15:0]; ey = ry[15:0]; ez = rz[15:0];
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic check_outs(input logic [15:0] ex, ey, ez, ew, input logic ec);
    chk("out_x", {16'h0, ox}, {16'h0, ex});
    chk("out_y", {16'h0, oy}, {16'h0, ey});
    chk("out_z", {16'h0, oz}, {16'h0, ez});
    chk("out_w", {16'h0, ow}, {16'h0, ew});
    chk("out_clip", {31'h0, oclip}, {31'h0, ec});
  endtask

  task automatic run_vec(input logic [31:0] a, b, c, d);
    logic [15:0] ex, ey, ez, ew;
    logic        ec;
    int          lat;
    model(a, b, c, d, ex, ey, ez, ew, ec);
    @(negedge clk);
    chk("in_ready_idle", {31'h0, in_ready}, 32'd1);
    y0 = a; y1 = b; y2 = c; y3 = d;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("latency", lat, ec ? 32'd2 : 32'd74);
    check_outs(ex, ey, ez, ew, ec);
    @(posedge clk); #1;
    chk("valid_drop", {31'h0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_comp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return r;
      1:       return {{8{r[23]}}, r[23:0]};
      default: return {{16{r[15]}}, r[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] rnd_w();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return r;
      1:       return {{16{r[15]}}, r[15:0]};
      default: return {9'd0, r[22:0]};
    endcase
  endfunction

  initial begin
    logic [15:0] ax, ay, az, aw, bx, by, bz, bw;
    logic        ac, bc, seen;
    int          lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    y0 = 32'h0; y1 = 32'h0; y2 = 32'h0; y3 = 32'h0;
    #12;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check_outs(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);

    // Directed vectors
    run_vec(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000);
    run_vec(32'h1234_5678, 32'h8765_4321, 32'h0000_1000, 32'h0000_0000);
    run_vec(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000);
    run_vec(32'h7FFF_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0100);
    run_vec(32'h0003_0000, 32'hFFF0_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_vec(32'h0000_0080, 32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_00FF);

    // Backpressure with a second vector held on the inputs
    model(32'h0005_0000, 32'hFFFD_0000, 32'h0001_8000, 32'h0004_0000, ax, ay, az, aw, ac);
    model(32'h0000_4000, 32'h0010_0000, 32'hFFFF_C000, 32'h0000_8000, bx, by, bz, bw, bc);
    @(negedge clk);
    y0 = 32'h0005_0000; y1 = 32'hFFFD_0000; y2 = 32'h0001_8000; y3 = 32'h0004_0000;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    y0 = 32'h0000_4000; y1 = 32'h0010_0000; y2 = 32'hFFFF_C000; y3 = 32'h0000_8000;
    wait_valid(lat);
    chk("bp_latency", lat, 32'd74);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", {31'h0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'h0, in_ready}, 32'd0);
      chk("bp_x_stable", {16'h0, ox}, {16'h0, ax});
      chk("bp_w_stable", {16'h0, ow}, {16'h0, aw});
    end
    check_outs(ax, ay, az, aw, ac);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_valid", {31'h0, out_valid}, 32'd0);
    chk("bp_handshake_idle", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", {31'h0, in_ready}, 32'd0);
    wait_valid(lat);
    chk("bp2_latency", lat, 32'd74);
    check_outs(bx, by, bz, bw, bc);
    @(posedge clk); #1;

    // Reset during the divide aborts the vector
    @(negedge clk);
    y0 = 32'h0009_0000; y1 = 32'h0002_0000; y2 = 32'h0001_0000; y3 = 32'h0003_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (31) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("abort_in_ready", {31'h0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'h0, out_valid}, 32'd0);
    check_outs(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {31'h0, seen}, 32'd0);
    run_vec(32'h0009_0000, 32'h0002_0000, 32'h0001_0000, 32'h0003_0000);

    // Randomized vectors against the reference model
    for (int n = 0; n < 500; n++) begin
      run_vec(rnd_comp(), rnd_comp(), rnd_comp(), rnd_w());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
